// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and instruction memory.
// The sequencer holds req and addr until it sees a one-cycle ack with rdata valid in that cycle.
interface fetch_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and issues one fetch at a time to instruction memory.
// Handles branch squash of in-flight fetches, decode-stall backpressure, and halt/resume.
module fetch_ctrl #(
   parameter int INST_ADDR_WIDTH   = 16,
   parameter int INST_WIDTH        = 16,
   parameter int NUM_BYTES_IN_INST = 2,
   parameter int RESET_ADDR        = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   fetch_ctrl_if.master               imem,
   input  logic                       stall,
   input  logic                       halt_dec,
   input  logic [INST_ADDR_WIDTH-1:0] id_pc,
   input  logic                       br_taken,
   input  logic [INST_ADDR_WIDTH-1:0] br_target,
   input  logic                       resume,
   output logic [INST_ADDR_WIDTH-1:0] pc,
   output logic [INST_WIDTH-1:0]      if_inst,
   output logic                       if_valid,
   output logic                       flush,
   output logic                       halted
);

   localparam logic [INST_ADDR_WIDTH-1:0] PC_INC  = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
   localparam logic [INST_ADDR_WIDTH-1:0] PC_RST  = INST_ADDR_WIDTH'(RESET_ADDR);

   typedef enum logic [2:0] {
      READY,
      REQ,
      DISCARD,
      DISCARD_H,
      HALTED
   } state_e;

   state_e                     state_q,  state_d;
   logic [INST_ADDR_WIDTH-1:0] pc_q,     pc_d;
   logic                       req_q,    req_d;
   logic [INST_ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [INST_WIDTH-1:0]      inst_q,   inst_d;
   logic                       valid_q,  valid_d;
   logic                       flush_q,  flush_d;
   logic                       halted_q, halted_d;

   always_comb begin
      // NOTE: every *_d gets a default before the case so no path can infer a latch.
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      valid_d = stall ? valid_q : 1'b0;
      flush_d = 1'b0;

      unique case (state_q)
         READY: begin
            if (br_taken) begin
               pc_d    = br_target;
               flush_d = 1'b1;
               valid_d = 1'b0;
            end else if (halt_dec) begin
               pc_d    = id_pc + PC_INC;
               flush_d = 1'b1;
               valid_d = 1'b0;
               state_d = HALTED;
            end else if (!(stall && valid_q)) begin
               addr_d  = pc_q;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end

         REQ: begin
            if (br_taken) begin
               pc_d    = br_target;
               flush_d = 1'b1;
               valid_d = 1'b0;
               if (imem.ack) begin
                  req_d   = 1'b0;
                  state_d = READY;
               end else begin
                  state_d = DISCARD;
               end
            end else if (halt_dec) begin
               pc_d    = id_pc + PC_INC;
               flush_d = 1'b1;
               valid_d = 1'b0;
               if (imem.ack) begin
                  req_d   = 1'b0;
                  state_d = HALTED;
               end else begin
                  state_d = DISCARD_H;
               end
            end else if (imem.ack) begin
               // Capture ignores stall: REQ is only entered when the slot is free or draining.
               inst_d  = imem.rdata;
               valid_d = 1'b1;
               pc_d    = pc_q + PC_INC;
               req_d   = 1'b0;
               state_d = READY;
            end
         end

         DISCARD, DISCARD_H: begin
            if (br_taken) begin
               pc_d    = br_target;
               flush_d = 1'b1;
               valid_d = 1'b0;
            end
            if (imem.ack) begin
               req_d   = 1'b0;
               state_d = (state_q == DISCARD) ? READY : HALTED;
            end
         end

         HALTED: begin
            if (resume) state_d = READY;
         end

         default: state_d = READY;
      endcase

      halted_d = (state_d == HALTED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= READY;
         pc_q     <= PC_RST;
         req_q    <= 1'b0;
         addr_q   <= '0;
         inst_q   <= '0;
         valid_q  <= 1'b0;
         flush_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         inst_q   <= inst_d;
         valid_q  <= valid_d;
         flush_q  <= flush_d;
         halted_q <= halted_d;
      end
   end

   assign imem.req  = req_q;
   assign imem.addr = addr_q;
   assign pc        = pc_q;
   assign if_inst   = inst_q;
   assign if_valid  = valid_q;
   assign flush     = flush_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: each vector drives one cycle of inputs and
// gives the hand-computed register outputs expected right after that rising edge.
module tb_fetch_ctrl;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        halt;
      logic [15:0] id_pc;
      logic        br;
      logic [15:0] tgt;
      logic        resume;
      logic        ack;
      logic [15:0] rdata;
   } in_t;

   typedef struct packed {
      logic        req;
      logic [15:0] addr;
      logic [15:0] pc;
      logic        valid;
      logic [15:0] inst;
      logic        flush;
      logic        halted;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, halt_dec, br_taken, resume;
   logic [15:0] id_pc, br_target, pc, if_inst;
   logic        if_valid, flush, halted;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_ctrl_if #(.ADDR_W(16), .DATA_W(16)) imem_bus ();

   fetch_ctrl #(
      .INST_ADDR_WIDTH(16), .INST_WIDTH(16), .NUM_BYTES_IN_INST(2), .RESET_ADDR(0)
   ) dut (
      .clk(clk), .rst(rst), .imem(imem_bus), .stall(stall), .halt_dec(halt_dec),
      .id_pc(id_pc), .br_taken(br_taken), .br_target(br_target), .resume(resume),
      .pc(pc), .if_inst(if_inst), .if_valid(if_valid), .flush(flush), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(
      input logic rst_i, stall_i, halt_i, input logic [15:0] id_pc_i,
      input logic br_i, input logic [15:0] tgt_i, input logic resume_i, ack_i,
      input logic [15:0] rdata_i,
      input logic req_e, input logic [15:0] addr_e, pc_e, input logic valid_e,
      input logic [15:0] inst_e, input logic flush_e, halted_e);
      vec_t v;
      v.i = '{rst_i, stall_i, halt_i, id_pc_i, br_i, tgt_i, resume_i, ack_i, rdata_i};
      v.o = '{req_e, addr_e, pc_e, valid_e, inst_e, flush_e, halted_e};
      return v;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got req=%0b addr=%h pc=%h valid=%0b inst=%h flush=%0b halted=%0b, want req=%0b addr=%h pc=%h valid=%0b inst=%h flush=%0b halted=%0b",
                  name, act.req, act.addr, act.pc, act.valid, act.inst, act.flush, act.halted,
                  exp.req, exp.addr, exp.pc, exp.valid, exp.inst, exp.flush, exp.halted);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      out_t obs;
      @(negedge clk);
      rst            = v.i.rst;
      stall          = v.i.stall;
      halt_dec       = v.i.halt;
      id_pc          = v.i.id_pc;
      br_taken       = v.i.br;
      br_target      = v.i.tgt;
      resume         = v.i.resume;
      imem_bus.ack   = v.i.ack;
      imem_bus.rdata = v.i.rdata;
      @(posedge clk);
      #1;
      obs = '{imem_bus.req, imem_bus.addr, pc, if_valid, if_inst, flush, halted};
      check(name, obs, v.o);
   endtask

   vec_t tbl[$];

   initial begin
      rst = 1'b1; stall = 1'b0; halt_dec = 1'b0; id_pc = '0; br_taken = 1'b0;
      br_target = '0; resume = 1'b0; imem_bus.ack = 1'b0; imem_bus.rdata = '0;

      // 1: reset, then four zero-wait fetches at 0,2,4,6
      tbl.push_back(mk(1,0,0,'h0,0,'h0,0,0,'h0,      0,'h0,'h0,0,'h0,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h0,'h0,0,'h0,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hA000,   0,'h0,'h2,1,'hA000,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h2,'h2,0,'hA000,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hA002,   0,'h2,'h4,1,'hA002,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h4,'h4,0,'hA002,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hA004,   0,'h4,'h6,1,'hA004,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h6,'h6,0,'hA004,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hA006,   0,'h6,'h8,1,'hA006,0,0));
      // 2: reset, fetch 0 and 2, then branch to 0x40 while fetch of 4 waits 3 cycles
      tbl.push_back(mk(1,0,0,'h0,0,'h0,0,0,'h0,      0,'h0,'h0,0,'h0,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h0,'h0,0,'h0,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hB000,   0,'h0,'h2,1,'hB000,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h2,'h2,0,'hB000,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hB002,   0,'h2,'h4,1,'hB002,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h4,'h4,0,'hB002,0,0));
      tbl.push_back(mk(0,0,0,'h0,1,'h40,0,0,'h0,     1,'h4,'h40,0,'hB002,1,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h4,'h40,0,'hB002,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h4,'h40,0,'hB002,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hDEAD,   0,'h4,'h40,0,'hB002,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h40,'h40,0,'hB002,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hC040,   0,'h40,'h42,1,'hC040,0,0));
      // 3: five stalled cycles with a valid instruction held, then drain
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(0,1,0,'h0,0,'h0,0,0,'h0,   0,'h40,'h42,1,'hC040,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h42,'h42,0,'hC040,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hC042,   0,'h42,'h44,1,'hC042,0,0));
      // 4: halt at id_pc 0x10; branch/halt ignored while halted; resume fetches 0x12
      tbl.push_back(mk(0,0,1,'h10,0,'h0,0,0,'h0,     0,'h42,'h12,0,'hC042,1,1));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      0,'h42,'h12,0,'hC042,0,1));
      tbl.push_back(mk(0,0,0,'h0,1,'h77,0,0,'h0,     0,'h42,'h12,0,'hC042,0,1));
      tbl.push_back(mk(0,0,1,'h30,0,'h0,0,0,'h0,     0,'h42,'h12,0,'hC042,0,1));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      0,'h42,'h12,0,'hC042,0,1));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,1,0,'h0,      0,'h42,'h12,0,'hC042,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h12,'h12,0,'hC042,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hC012,   0,'h12,'h14,1,'hC012,0,0));
      // 5: branch and halt together in READY, branch wins
      tbl.push_back(mk(0,0,1,'h30,1,'h20,0,0,'h0,    0,'h12,'h20,0,'hC012,1,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h20,'h20,0,'hC012,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hC020,   0,'h20,'h22,1,'hC020,0,0));
      // 6: pc wrap from 0xFFFE, reset during REQ, late ack ignored after reset
      tbl.push_back(mk(0,0,0,'h0,1,'hFFFE,0,0,'h0,   0,'h20,'hFFFE,0,'hC020,1,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'hFFFE,'hFFFE,0,'hC020,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hCFFE,   0,'hFFFE,'h0,1,'hCFFE,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h0,'h0,0,'hCFFE,0,0));
      tbl.push_back(mk(1,0,0,'h0,0,'h0,0,0,'h0,      0,'h0,'h0,0,'h0,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hBAD0,   1,'h0,'h0,0,'h0,0,0));
      tbl.push_back(mk(0,0,0,'h0,0,'h0,0,1,'hD000,   0,'h0,'h2,1,'hD000,0,0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Halt while a fetch is outstanding: DISCARD_H waits for the ack, then halts
      apply(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h2,'h2,0,'hD000,0,0),   "discard_h_req");
      apply(mk(0,0,1,'h50,0,'h0,0,0,'h0,     1,'h2,'h52,0,'hD000,1,0),  "discard_h_enter");
      apply(mk(0,0,0,'h0,0,'h0,0,1,'h1111,   0,'h2,'h52,0,'hD000,0,1),  "discard_h_ack");
      apply(mk(0,0,0,'h0,0,'h0,1,0,'h0,      0,'h2,'h52,0,'hD000,0,0),  "discard_h_resume");
      // Branch coincident with ack in REQ: data dropped, straight back to READY
      apply(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h52,'h52,0,'hD000,0,0), "br_ack_req");
      apply(mk(0,0,0,'h0,1,'h70,0,1,'hEEEE,  0,'h52,'h70,0,'hD000,1,0), "br_ack_drop");
      // Halt coincident with ack in REQ: data dropped, straight to HALTED
      apply(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h70,'h70,0,'hD000,0,0), "halt_ack_req");
      apply(mk(0,0,1,'h80,0,'h0,0,1,'h2222,  0,'h70,'h82,0,'hD000,1,1), "halt_ack_drop");
      apply(mk(0,0,0,'h0,0,'h0,1,0,'h0,      0,'h70,'h82,0,'hD000,0,0), "halt_ack_resume");
      // Second branch while discarding retargets pc and pulses flush again
      apply(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'h82,'h82,0,'hD000,0,0), "dbl_br_req");
      apply(mk(0,0,0,'h0,1,'h90,0,0,'h0,     1,'h82,'h90,0,'hD000,1,0), "dbl_br_first");
      apply(mk(0,0,0,'h0,1,'hA0,0,0,'h0,     1,'h82,'hA0,0,'hD000,1,0), "dbl_br_second");
      apply(mk(0,0,0,'h0,0,'h0,0,1,'h3333,   0,'h82,'hA0,0,'hD000,0,0), "dbl_br_ack");
      // Stall with an empty slot still fetches, and the ack is captured under stall
      apply(mk(0,1,0,'h0,0,'h0,0,0,'h0,      1,'hA0,'hA0,0,'hD000,0,0), "stall_empty_req");
      apply(mk(0,1,0,'h0,0,'h0,0,1,'hF0A0,   0,'hA0,'hA2,1,'hF0A0,0,0), "stall_capture");
      apply(mk(0,1,0,'h0,0,'h0,0,0,'h0,      0,'hA0,'hA2,1,'hF0A0,0,0), "stall_hold");
      apply(mk(0,0,0,'h0,0,'h0,0,0,'h0,      1,'hA2,'hA2,0,'hF0A0,0,0), "stall_release");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter register and drives the instruction-memory request handshake. It applies the same next-PC rules as the combinational PC adder (sequential +NUM_BYTES_IN_INST, branch redirect, halt hold). It also adds a fetch FSM, squashing of in-flight fetches on taken branches, decode-stall backpressure, and a halted state with resume. It sits between the instruction memory and the IF/ID stage, with inputs from the hazard unit (stall), decode (halt) and EX (branch).

Parameters:
INST_ADDR_WIDTH, 16, width of PC and memory address
INST_WIDTH, 16, instruction word width
NUM_BYTES_IN_INST, 2, PC increment per sequential fetch
RESET_ADDR, 0, PC value after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  INST_ADDR_WIDTH  fetch address; stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  in  INST_WIDTH  fetched instruction
stall  in  1  decode cannot accept a new instruction
halt_dec  in  1  instruction in ID is HALT
id_pc  in  INST_ADDR_WIDTH  PC of the instruction in ID
br_taken  in  1  EX resolved a taken branch this cycle
br_target  in  INST_ADDR_WIDTH  branch target
resume  in  1  leave halted state
pc  out  INST_ADDR_WIDTH  address of the next fetch
if_inst  out  INST_WIDTH  instruction to decode
if_valid  out  1  if_inst is valid
flush  out  1  one-cycle pulse, squash IF/ID
halted  out  1  high in HALTED state

Behaviour:
- Reset (rst=1 at edge) takes priority over everything:
  - state=READY, pc=RESET_ADDR, imem_req=0, imem_addr=0
  - if_inst=0, if_valid=0, flush=0, halted=0
  - A reset mid-transaction abandons it; a late imem_ack after reset in READY is ignored.
- All outputs are registered. flush defaults to 0 every cycle unless set below.
- Event priority each cycle: br_taken > halt_dec > stall.
- if_valid consumption: when stall=0 and no ack is captured this cycle, if_valid<=0. When stall=1, if_inst and if_valid hold.
- READY (imem_req=0):
  - br_taken: pc<=br_target, flush<=1, if_valid<=0, stay READY.
  - else halt_dec: pc<=id_pc+NUM_BYTES_IN_INST, if_valid<=0, flush<=1 -> HALTED.
  - else if !(stall && if_valid): imem_addr<=pc, imem_req<=1 -> REQ.
  - else stay READY.
- REQ (imem_req=1, imem_addr held):
  - br_taken with imem_ack: data dropped, pc<=br_target, flush<=1, if_valid<=0, imem_req<=0 -> READY.
  - br_taken without imem_ack: pc<=br_target, flush<=1, if_valid<=0 -> DISCARD; req and addr stay held.
  - halt_dec with ack: data dropped, pc<=id_pc+NUM_BYTES_IN_INST, flush<=1, if_valid<=0, imem_req<=0 -> HALTED.
  - halt_dec without ack: same pc, flush and if_valid update -> DISCARD_H.
  - imem_ack only: if_inst<=imem_rdata, if_valid<=1, pc<=pc+NUM_BYTES_IN_INST (mod 2^INST_ADDR_WIDTH, wraps), imem_req<=0 -> READY.
  - Stall never drops a request. REQ is entered only when the if_inst slot is free or draining.
- DISCARD: waits for the ack of the squashed fetch.
  - On imem_ack: drop data, imem_req<=0 -> READY.
  - A further br_taken in DISCARD updates pc and pulses flush; stay DISCARD.
- DISCARD_H: as DISCARD, but exits to HALTED on imem_ack.
- HALTED: halted=1, imem_req=0, pc held. br_taken and halt_dec are ignored.
  - resume=1 -> READY, with halted<=0 next cycle.
- Timing:
  - Minimum fetch latency is 1 cycle (READY->REQ) plus memory latency.
  - Peak throughput is one instruction per 2 cycles with a zero-wait ack.

Test Plan:
1. Reset then zero-wait memory (ack in the cycle after req rises), stall=0:
   - imem_addr sequence 0,2,4,6.
   - if_valid pulses carry the matching rdata.
   - pc=8 after the fourth ack.
2. Branch during an outstanding fetch: req at addr 4, ack delayed 3 cycles, br_taken with br_target=0x40 in the first wait cycle.
   - flush=1 for exactly one cycle.
   - The addr 4 data is never presented (if_valid stays 0).
   - The next request is addr 0x40.
3. Stall backpressure: if_valid=1, stall=1 for 5 cycles.
   - No new imem_req; if_inst is unchanged.
   - After stall drops, if_valid clears and the next request issues.
4. Halt with id_pc=0x10, then resume after 4 cycles.
   - halted=1, imem_req=0 throughout the halt.
   - After resume, the first request is addr 0x12.
5. Simultaneous br_taken (target 0x20) and halt_dec in READY.
   - The branch wins: halted stays 0, the next request is 0x20.
6. pc=0xFFFE with a sequential fetch ack -> pc wraps to 0x0000.
   - Also assert rst during REQ: the next cycle shows imem_req=0 and pc=RESET_ADDR.
